wm_cycle_controller: RTL and testbench

Master sequencing FSM for the washing-machine controller. It drives the 3-bit `state` bus consumed by the phase timer and advances on the timer's `sig_Full`, `sig_Temperature` and `sig_Completed` replies. It also decodes state into actuator enables and door lock, supports pause, repeats the rinse phase, and guards every timed phase with a watchdog that aborts to DONE with a fault flag.

---
 rtl/wm_cycle_controller.sv | 165 ++++++++++++++++
 tb/tb_wm_cycle_controller.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/wm_cycle_controller.sv
// Washing-machine master sequencer: walks the wash program phases, drives the phase code
// to the timer, decodes actuator enables, and aborts a stuck phase through a watchdog.
module wm_cycle_controller #(
    parameter int RINSE_PASSES    = 2,
    parameter int WATCHDOG_CYCLES = 1023
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       door_closed,
    input  logic       pause,
    input  logic       sig_Full,
    input  logic       sig_Temperature,
    input  logic       sig_Completed,
    output logic [2:0] state,
    output logic       water_valve,
    output logic       heater,
    output logic       motor,
    output logic       drain,
    output logic       door_lock,
    output logic       done,
    output logic       fault
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        CHECK_DOOR = 3'd1,
        FILL_WATER = 3'd2,
        HEAT_WATER = 3'd3,
        WASH       = 3'd4,
        RINSE      = 3'd5,
        SPIN       = 3'd6,
        DONE       = 3'd7
    } state_t;

    localparam logic [9:0] WD_LIMIT = 10'(WATCHDOG_CYCLES);

    state_t     state_reg, state_next;
    logic [1:0] rinse_cnt_reg, rinse_cnt_next;
    logic [9:0] wd_reg, wd_next, wd_inc;
    logic       entry_reg, entry_next;
    logic       fault_reg, fault_next;
    logic       water_valve_reg, heater_reg, motor_reg, drain_reg, door_lock_reg, done_reg;
    logic       water_valve_next, heater_next, motor_next, drain_next, door_lock_next, done_next;
    logic       timed, reply, qualified, reentry, run_next;

    function automatic logic is_timed(input state_t s);
        return (s == FILL_WATER) || (s == HEAT_WATER) || (s == WASH) ||
               (s == RINSE) || (s == SPIN);
    endfunction

    always_comb begin
        state_next     = state_reg;
        rinse_cnt_next = rinse_cnt_reg;
        wd_next        = wd_reg;
        entry_next     = entry_reg;
        fault_next     = fault_reg;
        reentry        = 1'b0;
        reply          = 1'b0;
        timed          = is_timed(state_reg);
        wd_inc         = (wd_reg == WD_LIMIT) ? wd_reg : wd_reg + 10'd1;

        case (state_reg)
            IDLE:       if (start) state_next = CHECK_DOOR;
            CHECK_DOOR: begin
                if (door_closed)  state_next = FILL_WATER;
                else if (!start)  state_next = IDLE;
            end
            FILL_WATER: reply = sig_Full;
            HEAT_WATER: reply = sig_Temperature;
            WASH, RINSE, SPIN: reply = sig_Completed;
            DONE: begin
                if (!start) begin
                    state_next = IDLE;
                    fault_next = 1'b0;
                end
            end
            default:    state_next = IDLE;
        endcase

        // The first cycle of a phase ignores replies so a stale timer reply cannot double-advance.
        qualified = reply && !entry_reg;

        if (timed && !pause) begin
            if (qualified) begin
                case (state_reg)
                    FILL_WATER: state_next = HEAT_WATER;
                    HEAT_WATER: state_next = WASH;
                    WASH: begin
                        state_next     = RINSE;
                        rinse_cnt_next = 2'd0;
                    end
                    RINSE: begin
                        if (int'(rinse_cnt_reg) + 1 < RINSE_PASSES) begin
                            rinse_cnt_next = rinse_cnt_reg + 2'd1;
                            reentry        = 1'b1;
                        end else begin
                            state_next = SPIN;
                        end
                    end
                    default:    state_next = DONE;
                endcase
            end else if (wd_inc == WD_LIMIT) begin
                state_next = DONE;
                fault_next = 1'b1;
            end else begin
                wd_next    = wd_inc;
                entry_next = 1'b0;
            end
        end

        if ((state_next != state_reg) || reentry) begin
            wd_next    = 10'd0;
            entry_next = 1'b1;
        end

        // Outputs are registered from the next state so they line up with the state bus.
        run_next         = !(pause && is_timed(state_next));
        water_valve_next = (state_next == FILL_WATER) && run_next;
        heater_next      = (state_next == HEAT_WATER) && run_next;
        motor_next       = ((state_next == WASH) || (state_next == RINSE) ||
                            (state_next == SPIN)) && run_next;
        drain_next       = ((state_next == RINSE) || (state_next == SPIN)) && run_next;
        door_lock_next   = is_timed(state_next);
        done_next        = (state_next == DONE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg       <= IDLE;
            rinse_cnt_reg   <= 2'd0;
            wd_reg          <= 10'd0;
            entry_reg       <= 1'b1;
            fault_reg       <= 1'b0;
            water_valve_reg <= 1'b0;
            heater_reg      <= 1'b0;
            motor_reg       <= 1'b0;
            drain_reg       <= 1'b0;
            door_lock_reg   <= 1'b0;
            done_reg        <= 1'b0;
        end else begin
            state_reg       <= state_next;
            rinse_cnt_reg   <= rinse_cnt_next;
            wd_reg          <= wd_next;
            entry_reg       <= entry_next;
            fault_reg       <= fault_next;
            water_valve_reg <= water_valve_next;
            heater_reg      <= heater_next;
            motor_reg       <= motor_next;
            drain_reg       <= drain_next;
            door_lock_reg   <= door_lock_next;
            done_reg        <= done_next;
        end
    end

    assign state       = state_reg;
    assign water_valve = water_valve_reg;
    assign heater      = heater_reg;
    assign motor       = motor_reg;
    assign drain       = drain_reg;
    assign door_lock   = door_lock_reg;
    assign done        = done_reg;
    assign fault       = fault_reg;

endmodule

// File: tb/tb_wm_cycle_controller.sv
// Directed bench for wm_cycle_controller: program flow, door wait, stale replies,
// pause, watchdog abort/precedence and asynchronous reset.
module tb_wm_cycle_controller;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       door_closed = 1'b0;
    logic       pause = 1'b0;
    logic       sig_Full = 1'b0;
    logic       sig_Temperature = 1'b0;
    logic       sig_Completed = 1'b0;
    logic [2:0] state;
    logic       water_valve, heater, motor, drain, door_lock, done, fault;

    int checks = 0;
    int errors = 0;

    wm_cycle_controller #(.RINSE_PASSES(2), .WATCHDOG_CYCLES(16)) dut (
        .clock(clock), .reset(reset), .start(start), .door_closed(door_closed),
        .pause(pause), .sig_Full(sig_Full), .sig_Temperature(sig_Temperature),
        .sig_Completed(sig_Completed), .state(state), .water_valve(water_valve),
        .heater(heater), .motor(motor), .drain(drain), .door_lock(door_lock),
        .done(done), .fault(fault)
    );

    always #5 clock = ~clock;

    // Outputs packed as {state, water_valve, heater, motor, drain, door_lock, done, fault}.
    function automatic logic [9:0] outs();
        return {state, water_valve, heater, motor, drain, door_lock, done, fault};
    endfunction

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_reset();
        start = 0; door_closed = 0; pause = 0;
        sig_Full = 0; sig_Temperature = 0; sig_Completed = 0;
        reset = 1;
        tick(2);
        reset = 0;
        tick(1);
    endtask

    task automatic pulse(input int which);
        case (which)
            0: sig_Full = 1;
            1: sig_Temperature = 1;
            default: sig_Completed = 1;
        endcase
        tick(1);
        sig_Full = 0; sig_Temperature = 0; sig_Completed = 0;
    endtask

    task automatic expect_outs(input string name, input logic [9:0] exp);
        checks++;
        if (outs() !== exp) begin
            errors++;
            $display("FAIL %s: outputs got %b expected %b", name, outs(), exp);
        end else
            $display("ok   %s: outputs %b", name, outs());
    endtask

    // Advances a freshly reset DUT into FILL_WATER.
    task automatic go_fill();
        door_closed = 1; start = 1;
        tick(2);
    endtask

    task automatic test_reset();
        do_reset();
        expect_outs("reset", 10'b000_0000000);
    endtask

    task automatic test_nominal();
        do_reset();
        door_closed = 1; start = 1;
        tick(1);  expect_outs("nom_check_door", 10'b001_0000000);
        tick(1);  expect_outs("nom_fill",       10'b010_1000100);
        tick(2);  pulse(0); expect_outs("nom_heat", 10'b011_0100100);
        tick(3);  pulse(1); expect_outs("nom_wash", 10'b100_0010100);
        tick(3);  pulse(0); expect_outs("nom_wash_ignores_full", 10'b100_0010100);
        tick(3);  pulse(2); expect_outs("nom_rinse1", 10'b101_0011100);
        tick(3);  pulse(2); expect_outs("nom_rinse2", 10'b101_0011100);
        tick(3);  pulse(2); expect_outs("nom_spin",   10'b110_0011100);
        tick(3);  pulse(2); expect_outs("nom_done",   10'b111_0000010);
        tick(3);  expect_outs("nom_done_held_start", 10'b111_0000010);
        start = 0;
        tick(1);  expect_outs("nom_idle", 10'b000_0000000);
    endtask

    task automatic test_door_open();
        int bad;
        do_reset();
        door_closed = 0; start = 1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (outs() !== 10'b001_0000000) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL door_wait: %0d bad cycles got %b expected 0010000000", bad, outs());
        end else
            $display("ok   door_wait: held CHECK_DOOR for 10 cycles");
        start = 0;
        tick(1); expect_outs("door_abandon", 10'b000_0000000);
    endtask

    task automatic test_stale_reply();
        do_reset();
        go_fill();
        tick(2); pulse(0); tick(3); pulse(1); tick(3);
        sig_Completed = 1;
        tick(1); expect_outs("stale_enter_rinse", 10'b101_0011100);
        tick(1); expect_outs("stale_blanked",     10'b101_0011100);
        sig_Completed = 0;
        tick(3); pulse(2); expect_outs("stale_second_pass", 10'b101_0011100);
        tick(3); pulse(2); expect_outs("stale_then_spin",   10'b110_0011100);
    endtask

    task automatic test_pause();
        int bad;
        do_reset();
        go_fill();
        tick(2); pulse(0);
        tick(2);
        pause = 1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 10) sig_Temperature = 1;
            tick(1);
            sig_Temperature = 0;
            if (outs() !== 10'b011_0000100) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL pause_hold: %0d bad cycles got %b expected 0110000100", bad, outs());
        end else
            $display("ok   pause_hold: HEAT frozen for 20 cycles");
        pause = 0;
        tick(1); expect_outs("pause_release", 10'b011_0100100);
        tick(4); expect_outs("pause_wd_held", 10'b011_0100100);
        pulse(1); expect_outs("pause_resume_wash", 10'b100_0010100);
    endtask

    task automatic test_watchdog();
        int bad;
        do_reset();
        go_fill();
        bad = 0;
        for (int i = 1; i < 16; i++) begin
            tick(1);
            if (state !== 3'd2) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL wd_early: %0d early exits got state %0d expected 2", bad, state);
        end else
            $display("ok   wd_early: FILL held 15 cycles");
        tick(1); expect_outs("wd_abort",     10'b111_0000011);
        tick(3); expect_outs("wd_fault_sticky", 10'b111_0000011);
        start = 0;
        tick(1); expect_outs("wd_clear", 10'b000_0000000);
    endtask

    task automatic test_precedence();
        do_reset();
        go_fill();
        tick(15);
        pulse(0); expect_outs("prec_completion_wins", 10'b011_0100100);
    endtask

    task automatic test_async_reset();
        do_reset();
        go_fill();
        tick(2); pulse(0); tick(3); pulse(1); tick(3); pulse(2);
        tick(3); pulse(2); tick(3); pulse(2);
        expect_outs("areset_in_spin", 10'b110_0011100);
        #2 reset = 1;
        #1 expect_outs("areset_immediate", 10'b000_0000000);
        reset = 0;
        start = 0;
        tick(1);
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_door_open();
        test_stale_reply();
        test_pause();
        test_watchdog();
        test_precedence();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
